// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready stream bundle for the pipelined CLA adder/subtractor.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One GROUP-bit lookahead slice per stage with the inter-group carry registered,
// so the critical path is a single group whatever WIDTH is. The whole pipe
// advances together (global stall) under valid/ready backpressure.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int STAGES = WIDTH / GROUP;

    if ((GROUP < 1) || (WIDTH % GROUP != 0)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end

    logic             adv;
    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    // The pipe moves whenever the output register is empty or being drained.
    assign adv           = !out_valid_reg || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        // Operand bits not yet consumed: [WIDTH-1 : gi*GROUP], right-aligned.
        localparam int REM  = WIDTH - gi * GROUP;

        logic                       vld_reg;
        logic [REM-1:0]             a_reg;
        logic [REM-1:0]             b_reg;
        logic                       c_reg;
        logic [GROUP-1:0]           g;
        logic [GROUP-1:0]           p;
        logic [GROUP:0]             c;
        logic                       la_acc;
        logic                       la_term;
        logic [GROUP-1:0]           grp_sum;
        logic [(gi+1)*GROUP-1:0]    s_merge;

        // Lookahead slice: every internal carry expanded as a flat sum of products.
        always_comb begin
            g       = a_reg[GROUP-1:0] & b_reg[GROUP-1:0];
            p       = a_reg[GROUP-1:0] ^ b_reg[GROUP-1:0];
            c       = '0;
            la_acc  = 1'b0;
            la_term = 1'b0;
            c[0]    = c_reg;
            for (int i = 0; i < GROUP; i++) begin
                la_acc = c_reg;
                for (int j = 0; j <= i; j++) begin
                    la_acc = la_acc & p[j];
                end
                for (int j = 0; j <= i; j++) begin
                    la_term = g[j];
                    for (int k = j + 1; k <= i; k++) begin
                        la_term = la_term & p[k];
                    end
                    la_acc = la_acc | la_term;
                end
                c[i+1] = la_acc;
            end
            grp_sum = p ^ c[GROUP-1:0];
        end

        if (gi == 0) begin : g_load
            assign s_merge = grp_sum;

            // Entry stage valid bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_reg <= 1'b0;
                end else if (adv) begin
                    vld_reg <= bus.in_valid;
                end
            end

            // Capture operands; subtract is a + ~b + 1 so cin is replaced by 1.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_reg <= bus.a;
                    b_reg <= bus.sub ? ~bus.b : bus.b;
                    c_reg <= bus.sub | bus.cin;
                end
            end
        end else begin : g_shift
            logic [gi*GROUP-1:0] s_reg;

            assign s_merge = {grp_sum, s_reg};

            // Valid bit follows the previous stage; bubbles travel as invalid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_reg <= 1'b0;
                end else if (adv) begin
                    vld_reg <= g_stage[gi-1].vld_reg;
                end
            end

            // Take resolved low sum bits, remaining operand bits and the group carry.
            always_ff @(posedge clk) begin
                if (adv) begin
                    s_reg <= g_stage[gi-1].s_merge;
                    a_reg <= g_stage[gi-1].a_reg[REM+GROUP-1:GROUP];
                    b_reg <= g_stage[gi-1].b_reg[REM+GROUP-1:GROUP];
                    c_reg <= g_stage[gi-1].c[GROUP];
                end
            end
        end
    end

    // Output register: last slice result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= g_stage[STAGES-1].vld_reg;
            if (g_stage[STAGES-1].vld_reg) begin
                sum_reg  <= g_stage[STAGES-1].s_merge;
                cout_reg <= g_stage[STAGES-1].c[GROUP];
                ovf_reg  <= g_stage[STAGES-1].c[GROUP] ^ g_stage[STAGES-1].c[GROUP-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=16, GROUP=4, latency 4).
module tb_pipelined_cla_adder;
    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int LAT   = 4;
    localparam int NVEC  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: {sum, cout, ovf}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [16:0] full;
        logic        ov;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + 17'd1;
            ov   = (a[15] != b[15]) && (full[15] != a[15]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            ov   = (a[15] == b[15]) && (full[15] != a[15]);
        end
        return {full[15:0], full[16], ov};
    endfunction

    // Present one beat, then measure latency and check the result.
    task automatic single(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [17:0] exp);
        int lat;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, lat, LAT);
        chk({name, "_result"}, {14'd0, bus.sum, bus.cout, bus.ovf}, {14'd0, exp});
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic        scin [8];
        logic        ssub [8];
        logic [17:0] sexp [8];
        logic [17:0] held;
        int sent, got, cyc, seen;

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h0000, 16'h8000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_outputs", {14'd0, bus.sum, bus.cout, bus.ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            single($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   {vecs[i].sum, vecs[i].cout, vecs[i].ovf});
        end

        // Back-to-back stream with a 3-cycle output stall
        for (int i = 0; i < 8; i++) begin
            sa[i]   = 16'($urandom);
            sb[i]   = 16'($urandom);
            scin[i] = 1'($urandom);
            ssub[i] = 1'($urandom);
            sexp[i] = model(sa[i], sb[i], scin[i], ssub[i]);
        end
        sent = 0;
        got  = 0;
        cyc  = 0;
        held = '0;
        while (got < 8 && cyc < 60) begin
            bus.out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                bus.a        = sa[sent];
                bus.b        = sb[sent];
                bus.cin      = scin[sent];
                bus.sub      = ssub[sent];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (!bus.out_ready) begin
                chk($sformatf("stall%0d_in_ready", cyc), {31'd0, bus.in_ready}, 32'd0);
                chk($sformatf("stall%0d_out_valid", cyc), {31'd0, bus.out_valid}, 32'd1);
                if (cyc == 6) begin
                    held = {bus.sum, bus.cout, bus.ovf};
                end else begin
                    chk($sformatf("stall%0d_hold", cyc), {14'd0, bus.sum, bus.cout, bus.ovf},
                        {14'd0, held});
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("stream%0d", got), {14'd0, bus.sum, bus.cout, bus.ovf},
                    {14'd0, sexp[got]});
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
            end
            step();
            cyc++;
        end
        chk("stream_count", got, 8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++) begin
            bus.a        = 16'h1111 * 16'(k + 1);
            bus.b        = 16'h0001;
            bus.cin      = 1'b0;
            bus.sub      = 1'b0;
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_stale", seen, 0);
        single("post_rst", 16'h1234, 16'h0FFF, 1'b0, 1'b0, {16'h2233, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
